// File: rtl/gsu_insn_fetch.sv
// GSU instruction fetch stage: 512-byte line-valid instruction cache in front of Game Pak ROM,
// with uncached ROM reads outside the CBR window and SNES-side cache RAM writes.
module gsu_insn_fetch #(
  parameter int LINE_BYTES = 16,
  parameter int NUM_LINES  = 32
) (
  input  logic        clkin,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic [15:0] pc,
  input  logic [7:0]  pbr,
  input  logic [15:0] cbr,
  input  logic        flush,
  output logic        fetch_ack,
  output logic [7:0]  fetch_data,
  output logic        busy,
  output logic        rom_req,
  output logic [23:0] rom_addr,
  input  logic        rom_ack,
  input  logic [7:0]  rom_data,
  input  logic        snes_we,
  input  logic [8:0]  snes_addr,
  input  logic [7:0]  snes_data,
  output logic [31:0] line_valid,
  output logic [2:0]  state_dbg
);

  localparam int CACHE_BYTES = LINE_BYTES * NUM_LINES;
  localparam int OFF_W       = $clog2(CACHE_BYTES);
  localparam int BYTE_W      = $clog2(LINE_BYTES);
  localparam int LINE_W      = OFF_W - BYTE_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_FILL   = 3'd2,
    S_ROMRD  = 3'd3,
    S_ACK    = 3'd4
  } state_t;

  // Handshakes: fetch_req is a one-cycle pulse honoured only in IDLE; fetch_ack is a one-cycle
  // pulse with fetch_data valid. rom_req rises with a stable rom_addr and holds until the cycle
  // rom_ack is seen; it is low for at least one cycle before the next ROM transaction.

  state_t                    state_q, state_d;
  logic [15-BYTE_W:0]        pc_hi_q, pc_hi_d;
  logic [7:0]                pbr_q, pbr_d;
  logic [OFF_W-1:0]          off_q, off_d;
  logic [BYTE_W-1:0]         fill_ptr_q, fill_ptr_d;
  logic                      abort_q, abort_d;
  logic [7:0]                result_q, result_d;
  logic                      hit_q, hit_d;
  logic [NUM_LINES-1:0]      flags_q, flags_d;
  logic                      busy_q, busy_d;
  logic                      fetch_ack_q, fetch_ack_d;
  logic                      rom_req_q, rom_req_d;
  logic [23:0]               rom_addr_q, rom_addr_d;

  logic [7:0]                mem [CACHE_BYTES];
  logic [7:0]                ram_rd_q;
  logic                      mem_we;
  logic [OFF_W-1:0]          mem_waddr;
  logic [7:0]                mem_wdata;
  logic [NUM_LINES-1:0]      flag_set;

  logic [15:0]               cbr_al;
  logic [16:0]               off_full;
  logic                      cacheable;
  logic [LINE_W-1:0]         line_now;

  // Unsigned 17-bit distance: a pc below the window base wraps to a large value and misses.
  assign cbr_al    = cbr & ~16'(LINE_BYTES - 1);
  assign off_full  = {1'b0, pc} - {1'b0, cbr_al};
  assign cacheable = off_full < 17'(CACHE_BYTES);
  assign line_now  = off_full[OFF_W-1:BYTE_W];

  always_comb begin
    state_d     = state_q;
    pc_hi_d     = pc_hi_q;
    pbr_d       = pbr_q;
    off_d       = off_q;
    fill_ptr_d  = fill_ptr_q;
    abort_d     = abort_q;
    result_d    = result_q;
    hit_d       = hit_q;
    busy_d      = busy_q;
    fetch_ack_d = 1'b0;
    rom_req_d   = rom_req_q;
    rom_addr_d  = rom_addr_q;
    mem_we      = 1'b0;
    mem_waddr   = '0;
    mem_wdata   = '0;
    flag_set    = '0;

    case (state_q)
      S_IDLE: begin
        if (snes_we) begin
          mem_we    = 1'b1;
          mem_waddr = snes_addr[OFF_W-1:0];
          mem_wdata = snes_data;
          if (snes_addr[BYTE_W-1:0] == '1) flag_set[snes_addr[OFF_W-1:BYTE_W]] = 1'b1;
        end
        if (fetch_req) begin
          pc_hi_d = pc[15:BYTE_W];
          pbr_d   = pbr;
          off_d   = off_full[OFF_W-1:0];
          busy_d  = 1'b1;
          hit_d   = 1'b0;
          if (cacheable && flags_q[line_now]) begin
            state_d = S_LOOKUP;
          end else if (cacheable) begin
            state_d    = S_FILL;
            fill_ptr_d = '0;
            abort_d    = 1'b0;
            rom_req_d  = 1'b1;
            rom_addr_d = {pbr, pc[15:BYTE_W], {BYTE_W{1'b0}}};
          end else begin
            state_d    = S_ROMRD;
            rom_req_d  = 1'b1;
            rom_addr_d = {pbr, pc};
          end
        end
      end

      S_LOOKUP: begin
        hit_d       = 1'b1;
        fetch_ack_d = 1'b1;
        state_d     = S_ACK;
      end

      S_FILL: begin
        if (flush) abort_d = 1'b1;
        if (rom_req_q && rom_ack) begin
          mem_we     = 1'b1;
          mem_waddr  = {off_q[OFF_W-1:BYTE_W], fill_ptr_q};
          mem_wdata  = rom_data;
          rom_req_d  = 1'b0;
          fill_ptr_d = fill_ptr_q + 1'b1;
          if (fill_ptr_q == off_q[BYTE_W-1:0]) result_d = rom_data;
          if (fill_ptr_q == '1) begin
            if (!abort_q) flag_set[off_q[OFF_W-1:BYTE_W]] = 1'b1;
            fetch_ack_d = 1'b1;
            state_d     = S_ACK;
          end
        end else if (!rom_req_q) begin
          rom_req_d  = 1'b1;
          rom_addr_d = {pbr_q, pc_hi_q, fill_ptr_q};
        end
      end

      S_ROMRD: begin
        if (rom_req_q && rom_ack) begin
          result_d    = rom_data;
          rom_req_d   = 1'b0;
          fetch_ack_d = 1'b1;
          state_d     = S_ACK;
        end
      end

      S_ACK: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    flags_d = flush ? '0 : (flags_q | flag_set);
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_hi_q     <= '0;
      pbr_q       <= '0;
      off_q       <= '0;
      fill_ptr_q  <= '0;
      abort_q     <= 1'b0;
      result_q    <= '0;
      hit_q       <= 1'b0;
      flags_q     <= '0;
      busy_q      <= 1'b0;
      fetch_ack_q <= 1'b0;
      rom_req_q   <= 1'b0;
      rom_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_hi_q     <= pc_hi_d;
      pbr_q       <= pbr_d;
      off_q       <= off_d;
      fill_ptr_q  <= fill_ptr_d;
      abort_q     <= abort_d;
      result_q    <= result_d;
      hit_q       <= hit_d;
      flags_q     <= flags_d;
      busy_q      <= busy_d;
      fetch_ack_q <= fetch_ack_d;
      rom_req_q   <= rom_req_d;
      rom_addr_q  <= rom_addr_d;
    end
  end

  // Cache RAM is not reset; its read register only loads during LOOKUP so the hit byte holds.
  always_ff @(posedge clkin) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (state_q == S_LOOKUP) ram_rd_q <= mem[off_q];
  end

  assign fetch_ack  = fetch_ack_q;
  assign fetch_data = hit_q ? ram_rd_q : result_q;
  assign busy       = busy_q;
  assign rom_req    = rom_req_q;
  assign rom_addr   = rom_addr_q;
  assign line_valid = 32'(flags_q);
  assign state_dbg  = state_q;

endmodule
